// File: rtl/cpc_ram_pkg.sv
// Shared types and helpers for the CPC RAM expansion banking controller.
//   cfg_mode_t  : the eight CPC RAM configurations C0..C7
//   cfg_t       : bank/mode part of the config register (block select is
//                 held alongside it because its width is a parameter)
//   wr_state_t  : states of the I/O write detector
//   PORT_D_TAG  : D[7:6] value that marks a write as a RAM config write
//   page_map()  : CPU page -> {mapped, expansion page} for a given mode
package cpc_ram_pkg;

  typedef enum logic [2:0] {
    C0 = 3'd0, C1 = 3'd1, C2 = 3'd2, C3 = 3'd3,
    C4 = 3'd4, C5 = 3'd5, C6 = 3'd6, C7 = 3'd7
  } cfg_mode_t;

  typedef struct packed {
    logic [2:0] bank;
    cfg_mode_t  mode;
  } cfg_t;

  typedef enum logic [1:0] {
    WR_IDLE     = 2'd0,
    WR_ARM      = 2'd1,
    WR_COMMIT   = 2'd2,
    WR_WAIT_END = 2'd3
  } wr_state_t;

  localparam logic [1:0] PORT_D_TAG = 2'b11;

  // Returns {mapped, epage[1:0]}.
  function automatic logic [2:0] page_map(input cfg_mode_t mode, input logic [1:0] page);
    logic [2:0] r;
    r = 3'b000;
    case (mode)
      C0: r = 3'b000;
      // C3 also moves page 1 internally; that is handled by the host.
      C1, C3: r = (page == 2'd3) ? 3'b111 : 3'b000;
      C2: r = {1'b1, page};
      // C4..C7 place expansion page (mode-4) in the 4000-7FFF window.
      default: r = (page == 2'd1) ? {1'b1, mode[1:0]} : 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_io_wr_det.sv
// I/O write detector for the RAM config port (&7Fxx, D[7:6]=11).
// A write is accepted only after FILT_CYC consecutive clock samples with
// the full qualifier present; it then produces a single-cycle o_wr_stb and
// holds the address block bits and data captured on the last sample.
// The FSM then waits for IOREQ_B to go high so one bus write commits once.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_ioreq_b, i_wr_b   Z80 strobes, active low
//   i_a15               CPU A15 (must be low for the config port)
//   i_a_blk             CPU A[8+:BLK_W], raw (not inverted)
//   i_d                 CPU data bus
//   o_wr_stb            one-cycle commit strobe (asserted while in COMMIT)
//   o_blk, o_d          captured A block bits and D[5:0]
module cpc_io_wr_det
  import cpc_ram_pkg::*;
#(
  parameter int BLK_W    = 3,
  parameter int FILT_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ioreq_b,
  input  logic             i_wr_b,
  input  logic             i_a15,
  input  logic [BLK_W-1:0] i_a_blk,
  input  logic [7:0]       i_d,
  output logic             o_wr_stb,
  output logic [BLK_W-1:0] o_blk,
  output logic [5:0]       o_d
);

  localparam int CNT_W = $clog2(FILT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  wr_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_qual;

  assign w_qual = ~i_ioreq_b & ~i_wr_b & ~i_a15 & (i_d[7:6] == PORT_D_TAG);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= WR_IDLE;
      r_cnt    <= '0;
      o_wr_stb <= 1'b0;
      o_blk    <= '0;
      o_d      <= '0;
    end else begin
      case (r_state)
        WR_IDLE: begin
          o_wr_stb <= 1'b0;
          if (w_qual) begin
            r_state <= WR_ARM;
            r_cnt   <= CNT_W'(1);
          end
        end
        WR_ARM: begin
          if (!w_qual) begin
            // Too short: treated as a glitch and discarded.
            r_state <= WR_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= WR_COMMIT;
            o_wr_stb <= 1'b1;
            o_blk    <= i_a_blk;
            o_d      <= i_d[5:0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WR_COMMIT: begin
          o_wr_stb <= 1'b0;
          r_state  <= WR_WAIT_END;
        end
        default: begin
          o_wr_stb <= 1'b0;
          if (i_ioreq_b) begin
            r_state <= WR_IDLE;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// Banking controller for the Amstrad CPC RAM expansion.
// Snoops config writes to &7Fxx, holds {blk, bank, mode} and maps CPU pages
// onto NUM_SRAM 512K SRAMs. The memory path is combinational from the
// registered config so a config write never changes a cycle mid-way.
// Optional feature: define RAMBANK_READBACK_EN to let the CPU read the
// config back on D during IN from the port; otherwise D is never driven.
// Ports:
//   i_clk, i_reset        CPC clock, asynchronous active-high reset
//   i_a                   CPU address
//   io_d                  CPU data bus
//   i_mreq_b, i_ioreq_b, i_rd_b, i_wr_b, i_rfsh_b  Z80 strobes, active low
//   i_dip                 [0] expansion enable, [1] 6128 mode
//   o_hiadr               SRAM A18:A14 = {bank, epage}
//   o_ramcs_b             per-chip select, active low
//   o_ramoe_b, o_ramwe_b  SRAM output/write enable, active low
//   o_ramdis              internal RAM disable, active high
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int NUM_SRAM = 2,
  parameter int BLK_W    = 3,
  parameter int FILT_CYC = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [15:0]         i_a,
  inout  wire  [7:0]          io_d,
  input  logic                i_mreq_b,
  input  logic                i_ioreq_b,
  input  logic                i_rd_b,
  input  logic                i_wr_b,
  input  logic                i_rfsh_b,
  input  logic [1:0]          i_dip,
  output logic [4:0]          o_hiadr,
  output logic [NUM_SRAM-1:0] o_ramcs_b,
  output logic                o_ramoe_b,
  output logic                o_ramwe_b,
  output logic                o_ramdis
);

  localparam logic [BLK_W:0] NUM_SRAM_W = (BLK_W + 1)'(NUM_SRAM);

  cfg_t             r_cfg;
  logic [BLK_W-1:0] r_blk;

  logic             w_wr_stb;
  logic [BLK_W-1:0] w_blk_lat;
  logic [5:0]       w_d_lat;
  logic [2:0]       w_map;
  logic             w_blk_ok;
  logic             w_6128_block;
  logic             w_hit;
  logic             w_sel;
  logic             w_unused;

  cpc_io_wr_det #(
    .BLK_W   (BLK_W),
    .FILT_CYC(FILT_CYC)
  ) u_wr_det (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_ioreq_b(i_ioreq_b),
    .i_wr_b   (i_wr_b),
    .i_a15    (i_a[15]),
    .i_a_blk  (i_a[8 +: BLK_W]),
    .i_d      (io_d),
    .o_wr_stb (w_wr_stb),
    .o_blk    (w_blk_lat),
    .o_d      (w_d_lat)
  );

  // Block select travels inverted on the address bus (&7Fxx -> block 0).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blk <= '0;
      r_cfg <= '{bank: 3'd0, mode: C0};
    end else if (w_wr_stb) begin
      r_blk      <= ~w_blk_lat;
      r_cfg.bank <= w_d_lat[5:3];
      r_cfg.mode <= cfg_mode_t'(w_d_lat[2:0]);
    end
  end

  assign w_map        = page_map(r_cfg.mode, i_a[15:14]);
  assign w_blk_ok     = ({1'b0, r_blk} < NUM_SRAM_W);
  // In 6128 mode block 0 bank 0 duplicates the internal 64K extension.
  assign w_6128_block = i_dip[1] & (r_blk == '0) & (r_cfg.bank == 3'd0);
  assign w_hit        = i_dip[0] & w_map[2] & w_blk_ok & ~w_6128_block;
  // Refresh cycles must never reach the SRAMs or disable internal RAM.
  assign w_sel        = w_hit & ~i_mreq_b & i_rfsh_b;

  generate
    for (genvar gi = 0; gi < NUM_SRAM; gi++) begin : g_cs
      assign o_ramcs_b[gi] = ~(w_sel & (r_blk == BLK_W'(gi)));
    end
  endgenerate

  assign o_ramoe_b = i_rd_b | ~w_hit;
  assign o_ramwe_b = i_wr_b | ~w_hit;
  assign o_ramdis  = w_sel;
  assign o_hiadr   = w_hit ? {r_cfg.bank, w_map[1:0]} : 5'd0;

`ifdef RAMBANK_READBACK_EN
  logic w_rb_en;
  assign w_rb_en = ~i_ioreq_b & ~i_rd_b & ~i_a[15];
  assign io_d    = w_rb_en ? {PORT_D_TAG, r_cfg.bank, r_cfg.mode} : 8'bz;
`else
  assign io_d = 8'bz;
`endif

  // Address bits outside the page/block fields are intentionally ignored.
  assign w_unused = ^i_a;

endmodule
